id_ex_stage: RTL and testbench

Decode stage plus ID/EX pipeline register for the 32-bit pipelined core. It takes the PC and instruction from the IF/ID register, reads a 32-entry register file with write-back bypass, and registers operands and decoded fields for EX. It detects load-use hazards, stalls the fetch side (PC and IF/ID) for one cycle, and turns EX-side branch redirects into bubbles.

---
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register.
// Reads a 32-entry register file with write-back bypass, captures operands and
// decoded fields for EX, detects load-use hazards and inserts bubbles on stall
// or on an EX-side redirect.
module id_ex_stage #(
    parameter int unsigned WIDTH = 32,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] InPC,
    input  logic [31:0]      InInst,
    input  logic             FLUSH,
    input  logic             WBEN,
    input  logic [4:0]       WBADDR,
    input  logic [WIDTH-1:0] WBDATA,
    output logic [WIDTH-1:0] PC,
    output logic [31:0]      Inst,
    output logic [WIDTH-1:0] RS1DATA,
    output logic [WIDTH-1:0] RS2DATA,
    output logic [4:0]       RS1,
    output logic [4:0]       RS2,
    output logic [4:0]       RD,
    output logic             MEMREAD,
    output logic             VALID,
    output logic             STALL
);

    localparam logic [6:0] OpLoad = 7'b0000011;

    // Register file storage; entry 0 is never written and never read.
    logic [WIDTH-1:0] regs [32];

    // Decoded fields of the incoming instruction.
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic [4:0]       dec_rd;
    logic [6:0]       dec_opcode;
    logic [WIDTH-1:0] rd1_val;
    logic [WIDTH-1:0] rd2_val;
    logic             bubble;

    assign dec_rs1    = InInst[19:15];
    assign dec_rs2    = InInst[24:20];
    assign dec_rd     = InInst[11:7];
    assign dec_opcode = InInst[6:0];

    // Register file write port; x0 writes are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (WBEN && (WBADDR != 5'd0)) begin
            regs[WBADDR] <= WBDATA;
        end
    end

    // Read ports with write-through bypass so WB and ID never conflict.
    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        if (dec_rs1 != 5'd0) begin
            if (WBEN && (WBADDR == dec_rs1)) begin
                rd1_val = WBDATA;
            end else begin
                rd1_val = regs[dec_rs1];
            end
        end
        if (dec_rs2 != 5'd0) begin
            if (WBEN && (WBADDR == dec_rs2)) begin
                rd2_val = WBDATA;
            end else begin
                rd2_val = regs[dec_rs2];
            end
        end
    end

    // Load-use hazard: both source fields compared regardless of opcode.
    // A redirect wins so the fetch side is free to follow the new PC.
    always_comb begin
        STALL = VALID && MEMREAD && (RD != 5'd0) &&
                ((RD == dec_rs1) || (RD == dec_rs2)) && !FLUSH;
    end

    assign bubble = FLUSH || STALL;

    // ID/EX register; a bubble leaves PC and operand data untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC      <= '0;
            Inst    <= NOP;
            RS1DATA <= '0;
            RS2DATA <= '0;
            RS1     <= 5'd0;
            RS2     <= 5'd0;
            RD      <= 5'd0;
            MEMREAD <= 1'b0;
            VALID   <= 1'b0;
        end else if (bubble) begin
            Inst    <= NOP;
            RS1     <= 5'd0;
            RS2     <= 5'd0;
            RD      <= 5'd0;
            MEMREAD <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            PC      <= InPC;
            Inst    <= InInst;
            RS1DATA <= rd1_val;
            RS2DATA <= rd2_val;
            RS1     <= dec_rs1;
            RS2     <= dec_rs2;
            RD      <= dec_rd;
            MEMREAD <= (dec_opcode == OpLoad);
            VALID   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage.
module tb_id_ex_stage;

    localparam logic [31:0] NOPI = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] InPC, InInst, WBDATA;
    logic        FLUSH, WBEN;
    logic [4:0]  WBADDR;
    logic [31:0] PC, Inst, RS1DATA, RS2DATA;
    logic [4:0]  RS1, RS2, RD;
    logic        MEMREAD, VALID, STALL;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(.WIDTH(32), .NOP(32'h00000013)) dut (
        .CLK(CLK), .RST(RST), .InPC(InPC), .InInst(InInst), .FLUSH(FLUSH),
        .WBEN(WBEN), .WBADDR(WBADDR), .WBDATA(WBDATA), .PC(PC), .Inst(Inst),
        .RS1DATA(RS1DATA), .RS2DATA(RS2DATA), .RS1(RS1), .RS2(RS2), .RD(RD),
        .MEMREAD(MEMREAD), .VALID(VALID), .STALL(STALL)
    );

    typedef struct {
        logic [31:0] pc, inst;
        logic        fl, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic [31:0] epc, einst, ed1, ed2;
        logic [4:0]  ers1, ers2, erd;
        logic        emr, ev;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw_i(input logic [4:0] rd, rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] pc, inst, input logic fl, we, input logic [4:0] wa,
        input logic [31:0] wd, input logic st, input logic [31:0] epc, einst, ed1, ed2,
        input logic [4:0] ers1, ers2, erd, input logic emr, ev);
        vec_t v;
        v.pc = pc; v.inst = inst; v.fl = fl; v.we = we; v.wa = wa; v.wd = wd;
        v.st = st; v.epc = epc; v.einst = einst; v.ed1 = ed1; v.ed2 = ed2;
        v.ers1 = ers1; v.ers2 = ers2; v.erd = erd; v.emr = emr; v.ev = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, ".PC"}, PC, v.epc);
        chk({tag, ".Inst"}, Inst, v.einst);
        chk({tag, ".RS1DATA"}, RS1DATA, v.ed1);
        chk({tag, ".RS2DATA"}, RS2DATA, v.ed2);
        chk({tag, ".RS1"}, 32'(RS1), 32'(v.ers1));
        chk({tag, ".RS2"}, 32'(RS2), 32'(v.ers2));
        chk({tag, ".RD"}, 32'(RD), 32'(v.erd));
        chk({tag, ".MEMREAD"}, 32'(MEMREAD), 32'(v.emr));
        chk({tag, ".VALID"}, 32'(VALID), 32'(v.ev));
    endtask

    task automatic drive(input logic [31:0] pc, inst, input logic fl, we,
                         input logic [4:0] wa, input logic [31:0] wd);
        InPC = pc; InInst = inst; FLUSH = fl; WBEN = we; WBADDR = wa; WBDATA = wd;
    endtask

    vec_t rst_v;

    initial begin
        // pc, inst, flush, wben, wbaddr, wbdata, stall | pc, inst, d1, d2, rs1, rs2, rd, mr, v
        vecs[0]  = mk(32'h100, add_i(1, 5, 0), 0, 1, 5, 32'hDEADBEEF, 0,
                      32'h100, add_i(1, 5, 0), 32'hDEADBEEF, 0, 5, 0, 1, 0, 1);
        vecs[1]  = mk(32'h104, add_i(2, 5, 5), 0, 0, 0, 0, 0,
                      32'h104, add_i(2, 5, 5), 32'hDEADBEEF, 32'hDEADBEEF, 5, 5, 2, 0, 1);
        vecs[2]  = mk(32'h108, add_i(6, 0, 7), 0, 1, 0, 32'hFFFFFFFF, 0,
                      32'h108, add_i(6, 0, 7), 0, 0, 0, 7, 6, 0, 1);
        vecs[3]  = mk(32'h10C, add_i(8, 0, 0), 0, 0, 0, 0, 0,
                      32'h10C, add_i(8, 0, 0), 0, 0, 0, 0, 8, 0, 1);
        vecs[4]  = mk(32'h110, lw_i(3, 5), 0, 1, 9, 32'h12345678, 0,
                      32'h110, lw_i(3, 5), 32'hDEADBEEF, 0, 5, 0, 3, 1, 1);
        vecs[5]  = mk(32'h114, add_i(10, 9, 3), 0, 0, 0, 0, 1,
                      32'h110, NOPI, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(32'h114, add_i(10, 9, 3), 0, 0, 0, 0, 0,
                      32'h114, add_i(10, 9, 3), 32'h12345678, 0, 9, 3, 10, 0, 1);
        vecs[7]  = mk(32'h118, lw_i(3, 9), 0, 0, 0, 0, 0,
                      32'h118, lw_i(3, 9), 32'h12345678, 0, 9, 0, 3, 1, 1);
        vecs[8]  = mk(32'h11C, add_i(11, 4, 0), 0, 0, 0, 0, 0,
                      32'h11C, add_i(11, 4, 0), 0, 0, 4, 0, 11, 0, 1);
        vecs[9]  = mk(32'h120, lw_i(0, 0), 0, 0, 0, 0, 0,
                      32'h120, lw_i(0, 0), 0, 0, 0, 0, 0, 1, 1);
        vecs[10] = mk(32'h124, add_i(12, 0, 0), 0, 0, 0, 0, 0,
                      32'h124, add_i(12, 0, 0), 0, 0, 0, 0, 12, 0, 1);
        vecs[11] = mk(32'h128, lw_i(3, 9), 0, 0, 0, 0, 0,
                      32'h128, lw_i(3, 9), 32'h12345678, 0, 9, 0, 3, 1, 1);
        vecs[12] = mk(32'h12C, add_i(13, 3, 0), 1, 0, 0, 0, 0,
                      32'h128, NOPI, 32'h12345678, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(32'h200, add_i(14, 9, 5), 0, 0, 0, 0, 0,
                      32'h200, add_i(14, 9, 5), 32'h12345678, 32'hDEADBEEF, 9, 5, 14, 0, 1);
        vecs[14] = mk(32'h204, add_i(15, 5, 0), 1, 0, 0, 0, 0,
                      32'h200, NOPI, 32'h12345678, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs[15] = mk(32'h208, lw_i(3, 0), 0, 0, 0, 0, 0,
                      32'h208, lw_i(3, 0), 0, 0, 0, 0, 3, 1, 1);
        vecs[16] = mk(32'h20C, add_i(16, 3, 3), 0, 1, 3, 32'hCAFEF00D, 1,
                      32'h208, NOPI, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(32'h20C, add_i(16, 3, 3), 0, 0, 0, 0, 0,
                      32'h20C, add_i(16, 3, 3), 32'hCAFEF00D, 32'hCAFEF00D, 3, 3, 16, 0, 1);
        rst_v = mk(0, 0, 0, 0, 0, 0, 0, 0, NOPI, 0, 0, 0, 0, 0, 0, 0);

        RST = 1'b1;
        drive(0, NOPI, 0, 0, 0, 0);
        #12;
        chk_outs("reset", rst_v);
        chk("reset.STALL", 32'(STALL), 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(vecs[i].pc, vecs[i].inst, vecs[i].fl, vecs[i].we, vecs[i].wa, vecs[i].wd);
            #1;
            chk($sformatf("v%0d.STALL", i), 32'(STALL), 32'(vecs[i].st));
            @(posedge CLK);
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle while VALID=1.
        @(negedge CLK);
        drive(32'h300, add_i(20, 3, 0), 0, 0, 0, 0);
        #1;
        chk("async.pre_VALID", 32'(VALID), 1);
        RST = 1'b1;
        #1;
        chk_outs("async", rst_v);
        chk("async.STALL", 32'(STALL), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Reset asserted while a stall is pending overrides it.
        drive(32'h304, lw_i(3, 0), 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        chk("rstall.load_VALID", 32'(VALID), 1);
        @(negedge CLK);
        drive(32'h308, add_i(17, 3, 0), 0, 0, 0, 0);
        #1;
        chk("rstall.STALL_pre", 32'(STALL), 1);
        RST = 1'b1;
        #1;
        chk("rstall.STALL_post", 32'(STALL), 0);
        chk("rstall.VALID", 32'(VALID), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Register file was cleared: x5 and x3 read back zero after reset.
        drive(32'h30C, add_i(18, 5, 3), 0, 0, 0, 0);
        #1;
        chk("postrst.STALL", 32'(STALL), 0);
        @(posedge CLK);
        #1;
        chk("postrst.VALID", 32'(VALID), 1);
        chk("postrst.PC", PC, 32'h30C);
        chk("postrst.RS1DATA", RS1DATA, 0);
        chk("postrst.RS2DATA", RS2DATA, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
